// File: rtl/imem_responder_pkg.sv
// Shared address/data sizes and helpers for the instruction-memory responder.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`define HBIT_ADDR 15
`define SIZE_DATA 32
`define HBIT_DATA 31
`endif

package imem_responder_pkg;

   localparam int unsigned CNT_W = 4;

   // True when a word address falls inside an array of the given depth.
   function automatic logic f_in_range(input logic [`HBIT_ADDR:0] addr,
                                       input int unsigned depth);
      return (32'(addr) < depth);
   endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one enabled registered read port.
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_wr_en,
   input  logic [`HBIT_ADDR:0]  i_wr_addr,
   input  logic [`HBIT_DATA:0]  i_wr_data,
   input  logic                 i_rd_en,
   input  logic [`HBIT_ADDR:0]  i_rd_addr,
   output logic [`HBIT_DATA:0]  o_rd_data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [`HBIT_DATA:0] r_mem [DEPTH];
   logic [`HBIT_DATA:0] r_rd_data;
   logic                w_wr_ok;
   logic                w_rd_ok;

   assign w_wr_ok   = i_wr_en && f_in_range(i_wr_addr, DEPTH);
   assign w_rd_ok   = f_in_range(i_rd_addr, DEPTH);
   assign o_rd_data = r_rd_data;

   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
      end
   end

   // Out-of-range reads return zero; a same-edge write is not visible yet.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= w_rd_ok ? r_mem[i_rd_addr[AW-1:0]] : '0;
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder with fixed wait latency, backpressure and flush.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned DEPTH       = 256
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst_n,
   input  logic                 iw_req_valid,
   output logic                 ow_req_ready,
   input  logic [`HBIT_ADDR:0]  iw_req_addr,
   input  logic                 iw_flush,
   output logic                 ow_rsp_valid,
   input  logic                 iw_rsp_ready,
   output logic [`HBIT_ADDR:0]  ow_rsp_addr,
   output logic [`HBIT_DATA:0]  ow_rsp_data,
   output logic                 ow_rsp_err,
   input  logic                 iw_wr_en,
   input  logic [`HBIT_ADDR:0]  iw_wr_addr,
   input  logic [`HBIT_DATA:0]  iw_wr_data
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam logic             LP_ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] LP_WAIT_LD   = CNT_W'(WAIT_CYCLES);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [`HBIT_ADDR:0] r_addr;
   logic                r_rsp_valid;
   logic [`HBIT_ADDR:0] r_rsp_addr;
   logic                r_rsp_err;

   logic                w_accept;
   logic                w_take;
   logic                w_rd_en;
   logic [`HBIT_ADDR:0] w_rd_addr;
   logic [`HBIT_DATA:0] w_rd_data;

   assign ow_req_ready = !iw_flush &&
                         ((r_state == ST_IDLE) || ((r_state == ST_RESP) && iw_rsp_ready));
   assign w_accept     = iw_req_valid && ow_req_ready;
   assign w_take       = r_rsp_valid && iw_rsp_ready;

   // The array is read on the cycle the FSM enters RESP.
   assign w_rd_addr = (r_state == ST_WAIT) ? r_addr : iw_req_addr;
   assign w_rd_en   = !iw_flush &&
                      ((w_accept && LP_ZERO_WAIT) ||
                       ((r_state == ST_WAIT) && (r_cnt <= CNT_W'(1))));

   assign ow_rsp_valid = r_rsp_valid;
   assign ow_rsp_addr  = r_rsp_addr;
   assign ow_rsp_data  = w_rd_data;
   assign ow_rsp_err   = r_rsp_err;

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_addr  <= '0;
         r_rsp_err   <= 1'b0;
      end else if (iw_flush) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_rd_en) begin
            r_rsp_addr <= w_rd_addr;
            r_rsp_err  <= !f_in_range(w_rd_addr, DEPTH);
         end
         case (r_state)
            ST_IDLE, ST_RESP: begin
               if (w_accept) begin
                  r_addr      <= iw_req_addr;
                  r_cnt       <= LP_WAIT_LD;
                  r_state     <= LP_ZERO_WAIT ? ST_RESP : ST_WAIT;
                  r_rsp_valid <= LP_ZERO_WAIT;
               end else if (w_take || (r_state == ST_IDLE)) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt <= CNT_W'(1)) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   imem_array #(.DEPTH(DEPTH)) u_array (
      .i_clk     (iw_clk),
      .i_rst_n   (iw_rst_n),
      .i_wr_en   (iw_wr_en),
      .i_wr_addr (iw_wr_addr),
      .i_wr_data (iw_wr_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

endmodule
